dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences every MEM-stage load/store onto the single-port data memory array.
- Generates byte enables, aligns store data, and extracts, zero-extends or sign-extends load data.
- Splits accesses that cross a word boundary into two word accesses and stalls the pipeline until the response is ready.
- Sits between the MEM stage (control-unit MemRead/MemWrite, ALU address, Funct3) and the 32-bit memory array.

Parameters:
- DM_ADDRESS, 9: byte-address width; the memory holds 2^(DM_ADDRESS-2) words.
- DATA_W, 32: data width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a request; held stable while stall=1.
- MemRead  in  1  load request; has priority if MemWrite is also 1.
- MemWrite  in  1  store request.
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- a  in  DM_ADDRESS  byte address.
- wd  in  DATA_W  store data, right-justified.
- stall  out  1  freeze the pipeline.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_err  out  1  illegal Funct3; qualified by resp_valid.
- rd  out  DATA_W  load result, registered; qualified by resp_valid.
- mem_addr  out  DM_ADDRESS  word-aligned address to the array; bits [1:0] are always 0.
- mem_re  out  1  array read strobe.
- mem_we  out  1  array write strobe.
- mem_be  out  4  byte-lane write enables; lane k is bits 8k+7:8k (little-endian).
- mem_wd  out  DATA_W  lane-aligned write data.
- mem_rd  in  DATA_W  array read data, valid the cycle after mem_re.

Behaviour:
- Reset: state=IDLE; stall, resp_valid, resp_err, mem_re, mem_we = 0; mem_be=0; rd=0; mem_addr=0; mem_wd=0.
- Accept: in IDLE, when req_valid && (MemRead || MemWrite), capture a, wd, Funct3 and direction at the edge.
  - req_valid with neither strobe set is ignored.
- Offset and size: o=a[1:0]; n=1/2/4 bytes; the access covers lanes o..o+n-1.
  - Lanes >= 4 map to word A+1 at lane-4. Such an access is a split.
  - Word A+1 wraps modulo the memory size, e.g. last word -> word 0.
- States: IDLE, ACC1, ACC2, RDW, RESP.
  - Aligned load: ACC1 (mem_re, word A) -> RDW (capture mem_rd) -> RESP.
  - Split load: ACC1 (re A) -> ACC2 (re A+1; capture A) -> RDW (capture A+1) -> RESP.
  - Aligned store: ACC1 (mem_we, mem_be=lanes, mem_wd=wd<<8o) -> RESP.
  - Split store: ACC1 (be=lanes in A, wd<<8o) -> ACC2 (A+1, be=remaining lanes, wd>>8(4-o)) -> RESP.
  - RESP: resp_valid=1, rd valid -> IDLE.
- Illegal Funct3:
  - Loads: 011, 110, 111 are illegal.
  - Stores: any value other than 000/001/010 is illegal.
  - Action: IDLE -> RESP directly, resp_err=1, rd=0, no array access.
- Latency (from accept edge to resp_valid): aligned load 3 cycles, split load 4, aligned store 2, split store 3, error 1.
- stall = req_valid && (MemRead || MemWrite) && state != RESP. It is combinational, so it is high in the accept cycle itself.
- Outside the active states, mem_re, mem_we and mem_be are 0.
- Load extract: byte/half is assembled from the captured lanes and right-justified.
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - W is passed as-is.
- No new request is accepted in RESP. The next request is sampled in IDLE on the following cycle.
- Reset mid-operation: immediately IDLE, all outputs to reset values, no response.
  - For a split store, a committed first half remains in memory; this is intended.

Decomposition:
- Package dmem_pkg:
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum dmem_state_t.
  - Function size_bytes(funct3).
  - Function is_legal(funct3, is_store).
- Sub-module dmem_lane_align: combinational.
  - Store side: computes first/second mem_be and mem_wd.
  - Load side: merges two captured words and sign/zero-extends.

Test Plan:
- LW a=0x010 after SW wd=0xDEADBEEF a=0x010:
  - SW: mem_be=1111, resp_valid 2 cycles after accept.
  - LW: rd=0xDEADBEEF, resp_valid 3 cycles after accept, stall high exactly 3 cycles.
- SB wd=0x000000A5 a=0x013 -> mem_be=1000, mem_wd=0xA5000000.
  - Then LB a=0x013 -> rd=0xFFFFFFA5; LBU a=0x013 -> rd=0x000000A5.
- Split SW wd=0x11223344 a=0x022:
  - ACC1: addr 0x020, be=1100, wd=0x33440000.
  - ACC2: addr 0x024, be=0011, wd=0x00001122.
  - Then LW a=0x022 -> rd=0x11223344, 4-cycle latency.
- Wrap: LH a=0x1FF -> second read at mem_addr 0x000.
  - rd = sign-extended {word0[7:0], word127[31:24]}.
- Funct3=011 load -> no mem_re, resp_valid + resp_err 1 cycle after accept, rd=0.
  - Funct3=100 store -> same error response with no mem_we.
- rst_n low during ACC2 of a split store: outputs 0 immediately, no resp_valid, only first-half bytes changed.
  - Next LW completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared Funct3 codes, FSM states and access-size helpers for
//               the data-memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC1 = 3'd1,
        ACC2 = 3'd2,
        RDW  = 3'd3,
        RESP = 3'd4
    } dmem_state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    // Unsigned variants only make sense for loads.
    function automatic logic is_legal(input logic [2:0] funct3, input logic is_store);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module      : dmem_lane_align
// Description : Byte-lane steering: store-side enables/data for both words of
//               a (possibly split) access, load-side merge and extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wd,
    input  logic [DATA_W-1:0] word_lo,
    input  logic [DATA_W-1:0] word_hi,
    output logic              split,
    output logic [3:0]        be_first,
    output logic [3:0]        be_second,
    output logic [DATA_W-1:0] wd_first,
    output logic [DATA_W-1:0] wd_second,
    output logic [DATA_W-1:0] load_data
);

    localparam logic [5:0] c_data_bits = 6'(DATA_W);

    logic [3:0]          w_mask;
    logic [7:0]          w_lanes;
    logic [4:0]          w_shift;
    logic [5:0]          w_hi_shift;
    logic [2*DATA_W-1:0] w_wd_wide;
    logic [DATA_W-1:0]   w_rd_word;

    always_comb begin
        w_mask = 4'b1111;
        case (size_bytes(funct3))
            3'd1:    w_mask = 4'b0001;
            3'd2:    w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    // Lanes 4..7 belong to the next word.
    assign w_lanes   = {4'b0000, w_mask} << offset;
    assign split     = |w_lanes[7:4];
    assign be_first  = w_lanes[3:0];
    assign be_second = w_lanes[7:4];

    assign w_shift   = {offset, 3'b000};
    assign w_wd_wide = {{DATA_W{1'b0}}, wd} << w_shift;
    assign wd_first  = w_wd_wide[DATA_W-1:0];
    assign wd_second = w_wd_wide[2*DATA_W-1:DATA_W];

    // A shift by the full width yields zero, so aligned accesses ignore word_hi.
    assign w_hi_shift = c_data_bits - {1'b0, w_shift};
    assign w_rd_word  = (word_lo >> w_shift) | (word_hi << w_hi_shift);

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{(DATA_W-8){w_rd_word[7]}}, w_rd_word[7:0]};
            F3_H:    load_data = {{(DATA_W-16){w_rd_word[15]}}, w_rd_word[15:0]};
            F3_W:    load_data = w_rd_word;
            F3_BU:   load_data = {{(DATA_W-8){1'b0}}, w_rd_word[7:0]};
            F3_HU:   load_data = {{(DATA_W-16){1'b0}}, w_rd_word[15:0]};
            default: load_data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module      : dmem_access_ctrl
// Description : Sequences MEM-stage loads/stores onto a single-port 32-bit
//               data array, splitting word-crossing accesses into two words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    output logic                  stall,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_W-1:0]     rd,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd
);

    dmem_state_t           r_state;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wd;
    logic [DATA_W-1:0]     r_word0;
    logic [2:0]            r_f3;
    logic                  r_store;

    logic                  w_req;
    logic                  w_idle;
    logic                  w_store;
    logic                  w_split;
    logic [1:0]            w_off;
    logic [2:0]            w_f3;
    logic [DATA_W-1:0]     w_wd;
    logic [DATA_W-1:0]     w_lo;
    logic [DATA_W-1:0]     w_wd_first;
    logic [DATA_W-1:0]     w_wd_second;
    logic [DATA_W-1:0]     w_load;
    logic [3:0]            w_be_first;
    logic [3:0]            w_be_second;
    logic [DM_ADDRESS-3:0] w_word_next;

    assign w_req   = req_valid && (MemRead || MemWrite);
    assign w_store = !MemRead;
    assign w_idle  = (r_state == IDLE);
    assign stall   = w_req && (r_state != RESP);

    // In IDLE the aligner sees the live request so ACC1 outputs can be registered at accept.
    assign w_off = w_idle ? a[1:0] : r_addr[1:0];
    assign w_f3  = w_idle ? Funct3 : r_f3;
    assign w_wd  = w_idle ? wd     : r_wd;
    assign w_lo  = w_split ? r_word0 : mem_rd;

    assign w_word_next = r_addr[DM_ADDRESS-1:2] + (DM_ADDRESS-2)'(1);

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .offset    (w_off),
        .funct3    (w_f3),
        .wd        (w_wd),
        .word_lo   (w_lo),
        .word_hi   (mem_rd),
        .split     (w_split),
        .be_first  (w_be_first),
        .be_second (w_be_second),
        .wd_first  (w_wd_first),
        .wd_second (w_wd_second),
        .load_data (w_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wd       <= '0;
            r_word0    <= '0;
            r_f3       <= '0;
            r_store    <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd         <= '0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_wd     <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= a;
                        r_wd    <= wd;
                        r_f3    <= Funct3;
                        r_store <= w_store;
                        if (!is_legal(Funct3, w_store)) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            rd         <= '0;
                        end else begin
                            r_state  <= ACC1;
                            mem_addr <= {a[DM_ADDRESS-1:2], 2'b00};
                            if (w_store) begin
                                mem_we <= 1'b1;
                                mem_be <= w_be_first;
                                mem_wd <= w_wd_first;
                            end else begin
                                mem_re <= 1'b1;
                            end
                        end
                    end
                end
                ACC1: begin
                    if (w_split) begin
                        r_state  <= ACC2;
                        mem_addr <= {w_word_next, 2'b00};
                        if (r_store) begin
                            mem_we <= 1'b1;
                            mem_be <= w_be_second;
                            mem_wd <= w_wd_second;
                        end else begin
                            mem_re <= 1'b1;
                        end
                    end else if (r_store) begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        rd         <= '0;
                    end else begin
                        r_state <= RDW;
                    end
                end
                ACC2: begin
                    if (r_store) begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        rd         <= '0;
                    end else begin
                        r_word0 <= mem_rd;
                        r_state <= RDW;
                    end
                end
                RDW: begin
                    rd         <= w_load;
                    resp_valid <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Directed plus random load/store checks of dmem_access_ctrl
//               against a byte-addressed reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;

    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;
    localparam int WORDS      = 128;
    localparam int BYTES      = 512;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid;
    logic                  MemRead;
    logic                  MemWrite;
    logic [2:0]            Funct3;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic                  stall;
    logic                  resp_valid;
    logic                  resp_err;
    logic [DATA_W-1:0]     rd;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [DATA_W-1:0]     mem_wd;
    logic [DATA_W-1:0]     mem_rd = '0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .DM_ADDRESS (DM_ADDRESS),
        .DATA_W     (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .a          (a),
        .wd         (wd),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .rd         (rd),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Array emulation (what the DUT drives) and byte-level reference (what it should hold).
    logic [31:0] arr  [WORDS];
    logic [7:0]  refb [BYTES];
    logic [31:0] w_tmp;

    logic [8:0]  wr_addr_q[$];
    logic [3:0]  wr_be_q[$];
    logic [31:0] wr_wd_q[$];
    logic [8:0]  re_addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int last_stall;

    logic [2:0] f3tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

    always @(posedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_be_q.push_back(mem_be);
            wr_wd_q.push_back(mem_wd);
            w_tmp = arr[mem_addr[8:2]];
            for (int k = 0; k < 4; k++)
                if (mem_be[k]) w_tmp[8*k +: 8] = mem_wd[8*k +: 8];
            arr[mem_addr[8:2]] <= w_tmp;
        end
        if (mem_re) begin
            re_addr_q.push_back(mem_addr);
            mem_rd <= arr[mem_addr[8:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_stall"},  {31'b0, stall},      0);
        chk({pfx, "_rvalid"}, {31'b0, resp_valid}, 0);
        chk({pfx, "_rerr"},   {31'b0, resp_err},   0);
        chk({pfx, "_rd"},     rd,                  0);
        chk({pfx, "_maddr"},  {23'b0, mem_addr},   0);
        chk({pfx, "_mre"},    {31'b0, mem_re},     0);
        chk({pfx, "_mwe"},    {31'b0, mem_we},     0);
        chk({pfx, "_mbe"},    {28'b0, mem_be},     0);
        chk({pfx, "_mwd"},    mem_wd,              0);
    endtask

    task automatic run_op(input bit st, input logic [2:0] f3, input logic [8:0] addr,
                          input logic [31:0] data, input bit both);
        int          n, cyc, stc, exp_lat, exp_acc;
        bit          legal, split, got;
        logic [31:0] exp_rd;
        logic [8:0]  base, base2;
        logic [8:0]  aq[$];

        legal   = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n       = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        split   = (int'(addr[1:0]) + n) > 4;
        base    = {addr[8:2], 2'b00};
        base2   = base + 9'd4;
        exp_lat = !legal ? 1 : st ? (split ? 3 : 2) : (split ? 4 : 3);
        exp_acc = !legal ? 0 : (split ? 2 : 1);
        exp_rd  = '0;
        if (legal && !st) begin
            for (int i = 0; i < n; i++)
                exp_rd = exp_rd | (32'(refb[(int'(addr) + i) % BYTES]) << (8 * i));
            if (!f3[2] && n == 1) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
            if (!f3[2] && n == 2) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
        end

        wr_addr_q.delete(); wr_be_q.delete(); wr_wd_q.delete(); re_addr_q.delete();
        req_valid = 1'b1;
        MemRead   = !st;
        MemWrite  = st | both;
        Funct3    = f3;
        a         = addr;
        wd        = data;

        got = 1'b0; cyc = 0; stc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall) stc++;
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        chk("resp_seen", {31'b0, got}, 1);
        chk("latency", cyc, exp_lat);
        chk("stall_cycles", stc, exp_lat);
        chk("resp_err", {31'b0, resp_err}, {31'b0, !legal});
        if (!st || !legal) chk("rd", rd, exp_rd);
        last_stall = stc;

        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        @(posedge clk);
        #1;

        chk("num_writes", wr_addr_q.size(), st ? exp_acc : 0);
        chk("num_reads",  re_addr_q.size(), st ? 0 : exp_acc);
        if (st) aq = wr_addr_q;
        else    aq = re_addr_q;
        if (exp_acc >= 1 && aq.size() >= 1) chk("addr_first",  {23'b0, aq[0]}, {23'b0, base});
        if (exp_acc == 2 && aq.size() >= 2) chk("addr_second", {23'b0, aq[1]}, {23'b0, base2});

        if (legal && st)
            for (int i = 0; i < n; i++)
                refb[(int'(addr) + i) % BYTES] = data[8*i +: 8];
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Funct3    = 3'd0;
        a         = '0;
        wd        = '0;
        for (int w = 0; w < WORDS; w++) begin
            arr[w] = $urandom;
            for (int k = 0; k < 4; k++) refb[4*w + k] = arr[w][8*k +: 8];
        end

        #12;
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Aligned word store then load-back.
        run_op(1'b1, 3'd2, 9'h010, 32'hDEADBEEF, 1'b0);
        if (wr_be_q.size() == 1) begin
            chk("sw_be", {28'b0, wr_be_q[0]}, 32'hF);
            chk("sw_wd", wr_wd_q[0], 32'hDEADBEEF);
        end
        run_op(1'b0, 3'd2, 9'h010, 32'h0, 1'b0);
        chk("lw_stall3", last_stall, 3);

        // Byte store into the top lane, then signed and unsigned byte loads.
        run_op(1'b1, 3'd0, 9'h013, 32'h000000A5, 1'b0);
        if (wr_be_q.size() == 1) begin
            chk("sb_be", {28'b0, wr_be_q[0]}, 32'h8);
            chk("sb_wd", wr_wd_q[0], 32'hA5000000);
        end
        run_op(1'b0, 3'd0, 9'h013, 32'h0, 1'b0);
        chk("lb_value", rd, 32'hFFFFFFA5);
        run_op(1'b0, 3'd4, 9'h013, 32'h0, 1'b0);
        chk("lbu_value", rd, 32'h000000A5);

        // Word store straddling two words.
        run_op(1'b1, 3'd2, 9'h022, 32'h11223344, 1'b0);
        if (wr_be_q.size() == 2) begin
            chk("split_be1", {28'b0, wr_be_q[0]}, 32'hC);
            chk("split_wd1", wr_wd_q[0], 32'h33440000);
            chk("split_be2", {28'b0, wr_be_q[1]}, 32'h3);
            chk("split_wd2", wr_wd_q[1], 32'h00001122);
        end
        run_op(1'b0, 3'd2, 9'h022, 32'h0, 1'b0);
        chk("split_lw_value", rd, 32'h11223344);

        // Halfword load wrapping from the last word to word 0.
        run_op(1'b0, 3'd1, 9'h1FF, 32'h0, 1'b0);

        // Illegal Funct3 for a load and a store.
        run_op(1'b0, 3'd3, 9'h040, 32'h0, 1'b0);
        run_op(1'b1, 3'd4, 9'h044, 32'h12345678, 1'b0);

        // Request with neither strobe must be ignored.
        wr_addr_q.delete(); re_addr_q.delete();
        req_valid = 1'b1;
        a         = 9'h050;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nostrobe_stall", {31'b0, stall}, 0);
            chk("nostrobe_rvalid", {31'b0, resp_valid}, 0);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("nostrobe_acc", wr_addr_q.size() + re_addr_q.size(), 0);

        // Reset during the second half of a split store.
        run_op(1'b0, 3'd2, 9'h010, 32'h0, 1'b0);
        req_valid = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        Funct3    = 3'd2;
        a         = 9'h0A3;
        wd        = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("acc2_we",   {31'b0, mem_we}, 1);
        chk("acc2_be",   {28'b0, mem_be}, 32'h7);
        chk("acc2_addr", {23'b0, mem_addr}, 32'h0A4);
        chk("acc2_wd",   mem_wd, 32'h00CAFEF0);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        MemWrite  = 1'b0;
        #1;
        chk_quiet("midreset");
        refb[9'h0A3] = 8'h0D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midreset_noresp", {31'b0, resp_valid}, 0);
            if (i == 1) rst_n = 1'b1;
        end
        @(posedge clk);
        #1;
        run_op(1'b0, 3'd2, 9'h0A0, 32'h0, 1'b0);
        run_op(1'b0, 3'd2, 9'h0A4, 32'h0, 1'b0);

        // Random mix, including illegal codes and simultaneous strobes.
        for (int t = 0; t < 80; t++) begin
            bit          r_st;
            logic [8:0]  r_addr;
            r_st   = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 31)) : 9'($urandom_range(0, 511));
            run_op(r_st, f3tab[$urandom_range(0, 9)], r_addr, $urandom, 1'($urandom_range(0, 1)));
        end

        for (int w = 0; w < WORDS; w++)
            chk($sformatf("array_word_%0d", w), arr[w],
                {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
